// File: rtl/ip_stack_pkg.sv
// ip_stack_pkg: definitions shared by the IP TX arbitration logic.
//   - IP protocol numbers driven on ip_send_type
//   - arbiter state encoding and source identifiers
//   - default AXIS widths of the TX payload path
package ip_stack_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  localparam logic [7:0] IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0] IP_PROTO_ICMP = 8'h01;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PASS      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_UDP  = 1'b0,
    SRC_ICMP = 1'b1
  } arb_src_e;

endpackage

// File: rtl/ip_tx_rr_pick.sv
// ip_tx_rr_pick: 2-way round-robin / priority picker.
// Ports:
//   req_i        [1:0] requests, bit 0 = UDP, bit 1 = ICMP
//   last_grant_i       source that completed the previous packet
//   prio_i             1 = ICMP wins every tie, 0 = round-robin
//   gnt_o        [1:0] one-hot grant (all zero when nothing requests)
module ip_tx_rr_pick
  import ip_stack_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_src_e   last_grant_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  // Grant selection; on a tie the source that did not go last wins unless ICMP has priority.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        if (prio_i) begin
          gnt_o = 2'b10;
        end else if (last_grant_i == SRC_ICMP) begin
          gnt_o = 2'b01;
        end else begin
          gnt_o = 2'b10;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: packet-level arbiter sharing the us_ip_tx payload path between
// the UDP TX and ICMP TX streams. The granted stream is muxed straight through
// (no added latency); ip_send_type and the grant are held until us_ip_tx
// reports the frame done (or the done timeout expires).
// Ports:
//   tx_axis_aclk / tx_axis_areset    clock, synchronous active-high reset
//   udp_tx_axis_*  / icmp_tx_axis_*  upstream AXIS sources (tready out)
//   ip_tx_axis_*                     AXIS towards us_ip_tx (tready in)
//   ip_send_type                     protocol number of the granted source
//   ip_tx_done                       us_ip_tx end-of-frame pulse
//   grant_udp / grant_icmp           registered grant flags
//   timeout_err                      one-cycle pulse on forced release
module ip_tx_arbiter
  import ip_stack_pkg::*;
#(
  parameter int         DATA_W        = AXIS_DATA_W,
  parameter int         KEEP_W        = AXIS_KEEP_W,
  parameter logic [7:0] UDP_TYPE      = IP_PROTO_UDP,
  parameter logic [7:0] ICMP_TYPE     = IP_PROTO_ICMP,
  parameter int         ICMP_PRIORITY = 0,
  parameter int         DONE_TIMEOUT  = 1024
) (
  input  logic              tx_axis_aclk,
  input  logic              tx_axis_areset,
  input  logic [DATA_W-1:0] udp_tx_axis_tdata,
  input  logic [KEEP_W-1:0] udp_tx_axis_tkeep,
  input  logic              udp_tx_axis_tvalid,
  input  logic              udp_tx_axis_tlast,
  output logic              udp_tx_axis_tready,
  input  logic [DATA_W-1:0] icmp_tx_axis_tdata,
  input  logic [KEEP_W-1:0] icmp_tx_axis_tkeep,
  input  logic              icmp_tx_axis_tvalid,
  input  logic              icmp_tx_axis_tlast,
  output logic              icmp_tx_axis_tready,
  output logic [DATA_W-1:0] ip_tx_axis_tdata,
  output logic [KEEP_W-1:0] ip_tx_axis_tkeep,
  output logic              ip_tx_axis_tvalid,
  output logic              ip_tx_axis_tlast,
  input  logic              ip_tx_axis_tready,
  output logic [7:0]        ip_send_type,
  input  logic              ip_tx_done,
  output logic              grant_udp,
  output logic              grant_icmp,
  output logic              timeout_err
);

  // With DONE_TIMEOUT = 0 the counter only saturates and never forces a release.
  localparam int             CNT_W    = (DONE_TIMEOUT > 0) ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam bit             TO_EN    = (DONE_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (DONE_TIMEOUT > 0) ? CNT_W'(DONE_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e       state_q, state_d;
  arb_src_e         last_grant_q, last_grant_d;
  logic             gnt_udp_q, gnt_udp_d;
  logic             gnt_icmp_q, gnt_icmp_d;
  logic [7:0]       send_type_q, send_type_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] pick_gnt;
  logic       in_pass;
  logic       hs_last;

  ip_tx_rr_pick u_pick (
    .req_i        ({icmp_tx_axis_tvalid, udp_tx_axis_tvalid}),
    .last_grant_i (last_grant_q),
    .prio_i       (ICMP_PRIORITY != 0),
    .gnt_o        (pick_gnt)
  );

  assign in_pass = (state_q == PASS);
  assign hs_last = ip_tx_axis_tvalid & ip_tx_axis_tready & ip_tx_axis_tlast;

  // Datapath mux: the granted source is connected straight through only while in PASS.
  always_comb begin
    ip_tx_axis_tdata    = udp_tx_axis_tdata;
    ip_tx_axis_tkeep    = udp_tx_axis_tkeep;
    ip_tx_axis_tlast    = udp_tx_axis_tlast;
    ip_tx_axis_tvalid   = 1'b0;
    udp_tx_axis_tready  = 1'b0;
    icmp_tx_axis_tready = 1'b0;
    if (in_pass && gnt_icmp_q) begin
      ip_tx_axis_tdata    = icmp_tx_axis_tdata;
      ip_tx_axis_tkeep    = icmp_tx_axis_tkeep;
      ip_tx_axis_tlast    = icmp_tx_axis_tlast;
      ip_tx_axis_tvalid   = icmp_tx_axis_tvalid;
      icmp_tx_axis_tready = ip_tx_axis_tready;
    end else if (in_pass && gnt_udp_q) begin
      ip_tx_axis_tvalid  = udp_tx_axis_tvalid;
      udp_tx_axis_tready = ip_tx_axis_tready;
    end else begin
      ip_tx_axis_tvalid = 1'b0;
    end
  end

  // Next-state logic: arbitrate in IDLE, stream in PASS, wait for frame completion in WAIT_DONE.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_udp_d     = gnt_udp_q;
    gnt_icmp_d    = gnt_icmp_q;
    send_type_d   = send_type_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_gnt != 2'b00) begin
          gnt_udp_d   = pick_gnt[0];
          gnt_icmp_d  = pick_gnt[1];
          send_type_d = pick_gnt[1] ? ICMP_TYPE : UDP_TYPE;
          state_d     = PASS;
        end else begin
          gnt_udp_d  = 1'b0;
          gnt_icmp_d = 1'b0;
        end
      end
      PASS: begin
        cnt_d = '0;
        // A done pulse before the last beat belongs to an earlier frame and is ignored.
        if (hs_last) begin
          last_grant_d = gnt_icmp_q ? SRC_ICMP : SRC_UDP;
          if (ip_tx_done) begin
            gnt_udp_d  = 1'b0;
            gnt_icmp_d = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_DONE;
          end
        end else begin
          state_d = PASS;
        end
      end
      WAIT_DONE: begin
        // Done wins over a coinciding timeout.
        if (ip_tx_done) begin
          gnt_udp_d  = 1'b0;
          gnt_icmp_d = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          gnt_udp_d     = 1'b0;
          gnt_icmp_d    = 1'b0;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        gnt_udp_d  = 1'b0;
        gnt_icmp_d = 1'b0;
        cnt_d      = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      state_q       <= IDLE;
      last_grant_q  <= SRC_ICMP;
      gnt_udp_q     <= 1'b0;
      gnt_icmp_q    <= 1'b0;
      send_type_q   <= UDP_TYPE;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_udp_q     <= gnt_udp_d;
      gnt_icmp_q    <= gnt_icmp_d;
      send_type_q   <= send_type_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign ip_send_type = send_type_q;
  assign grant_udp    = gnt_udp_q;
  assign grant_icmp   = gnt_icmp_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
`timescale 1ns/1ps
module tb_ip_tx_arbiter;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    beat_t      b;
    logic [7:0] ptype;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] udp_tdata, icmp_tdata, ip_tdata;
  logic [7:0]  udp_tkeep, icmp_tkeep, ip_tkeep;
  logic        udp_tvalid, udp_tlast, udp_tready;
  logic        icmp_tvalid, icmp_tlast, icmp_tready;
  logic        ip_tvalid, ip_tlast, ip_tready;
  logic [7:0]  ip_send_type;
  logic        ip_tx_done;
  logic        grant_udp, grant_icmp, timeout_err;
  logic        tb_hs_last;

  beat_t udp_src_q[$];
  beat_t icmp_src_q[$];
  exp_t  sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int beat_cnt = 0;
  int done_delay = 5;
  bit rdy_toggle = 1'b0;

  always #5 clk = ~clk;

  assign tb_hs_last = ip_tvalid & ip_tready & ip_tlast;

  ip_tx_arbiter #(
    .DATA_W(64), .KEEP_W(8), .UDP_TYPE(8'h11), .ICMP_TYPE(8'h01),
    .ICMP_PRIORITY(0), .DONE_TIMEOUT(16)
  ) dut (
    .tx_axis_aclk        (clk),
    .tx_axis_areset      (rst),
    .udp_tx_axis_tdata   (udp_tdata),
    .udp_tx_axis_tkeep   (udp_tkeep),
    .udp_tx_axis_tvalid  (udp_tvalid),
    .udp_tx_axis_tlast   (udp_tlast),
    .udp_tx_axis_tready  (udp_tready),
    .icmp_tx_axis_tdata  (icmp_tdata),
    .icmp_tx_axis_tkeep  (icmp_tkeep),
    .icmp_tx_axis_tvalid (icmp_tvalid),
    .icmp_tx_axis_tlast  (icmp_tlast),
    .icmp_tx_axis_tready (icmp_tready),
    .ip_tx_axis_tdata    (ip_tdata),
    .ip_tx_axis_tkeep    (ip_tkeep),
    .ip_tx_axis_tvalid   (ip_tvalid),
    .ip_tx_axis_tlast    (ip_tlast),
    .ip_tx_axis_tready   (ip_tready),
    .ip_send_type        (ip_send_type),
    .ip_tx_done          (ip_tx_done),
    .grant_udp           (grant_udp),
    .grant_icmp          (grant_icmp),
    .timeout_err         (timeout_err)
  );

  // UDP source: present the queue head, pop it once the handshake has happened.
  initial begin : udp_drv
    bit hs;
    beat_t b;
    udp_tvalid = 1'b0; udp_tdata = 64'h0; udp_tkeep = 8'h0; udp_tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = udp_tvalid && udp_tready;
      @(posedge clk);
      #1;
      if (hs && udp_src_q.size() > 0) b = udp_src_q.pop_front();
      if (udp_src_q.size() > 0) begin
        udp_tvalid = 1'b1; udp_tdata = udp_src_q[0].data;
        udp_tkeep = udp_src_q[0].keep; udp_tlast = udp_src_q[0].last;
      end else begin
        udp_tvalid = 1'b0; udp_tlast = 1'b0;
      end
    end
  end

  // ICMP source, same behaviour as the UDP source.
  initial begin : icmp_drv
    bit hs;
    beat_t b;
    icmp_tvalid = 1'b0; icmp_tdata = 64'h0; icmp_tkeep = 8'h0; icmp_tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = icmp_tvalid && icmp_tready;
      @(posedge clk);
      #1;
      if (hs && icmp_src_q.size() > 0) b = icmp_src_q.pop_front();
      if (icmp_src_q.size() > 0) begin
        icmp_tvalid = 1'b1; icmp_tdata = icmp_src_q[0].data;
        icmp_tkeep = icmp_src_q[0].keep; icmp_tlast = icmp_src_q[0].last;
      end else begin
        icmp_tvalid = 1'b0; icmp_tlast = 1'b0;
      end
    end
  end

  // Sink ready: constant 1 or alternating every cycle.
  initial begin : rdy_drv
    ip_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ip_tready = rdy_toggle ? ~ip_tready : 1'b1;
    end
  end

  // us_ip_tx stand-in: pulse done done_delay cycles after the last beat (0 = same cycle, <0 = never).
  initial begin : done_drv
    int cnt;
    cnt = -1;
    ip_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = -1;
      end else if (tb_hs_last) begin
        if (done_delay == 0) ip_tx_done = 1'b1;
        else if (done_delay > 0) cnt = done_delay;
        else cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ip_tx_done = 1'b1;
      end
      @(posedge clk);
      #1;
      ip_tx_done = 1'b0;
    end
  end

  // Scoreboard: every accepted output beat is compared with the next expected beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ip_tvalid && ip_tready) begin
      n_tests++;
      beat_cnt++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got data=%h keep=%h last=%b type=%h, want no beat", ip_tdata, ip_tkeep, ip_tlast, ip_send_type);
      end else begin
        e = sb_q.pop_front();
        if ({ip_tdata, ip_tkeep, ip_tlast, ip_send_type} !== {e.b.data, e.b.keep, e.b.last, e.ptype}) begin
          n_fail++;
          $display("FAIL beat_check: got data=%h keep=%h last=%b type=%h, want data=%h keep=%h last=%b type=%h",
                   ip_tdata, ip_tkeep, ip_tlast, ip_send_type, e.b.data, e.b.keep, e.b.last, e.ptype);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_pkt(input bit is_icmp, input int nbeats, input logic [63:0] base, input logic [7:0] last_keep);
    beat_t b;
    exp_t  e;
    for (int i = 1; i <= nbeats; i++) begin
      b.data = base + 64'(i);
      b.keep = (i == nbeats) ? last_keep : 8'hff;
      b.last = (i == nbeats);
      if (is_icmp) icmp_src_q.push_back(b);
      else udp_src_q.push_back(b);
      e.b = b;
      e.ptype = is_icmp ? 8'h01 : 8'h11;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({grant_udp, grant_icmp, timeout_err, udp_tready, icmp_tready, ip_tvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gu=%b gi=%b to=%b ur=%b ir=%b v=%b, want all 0",
               grant_udp, grant_icmp, timeout_err, udp_tready, icmp_tready, ip_tvalid);
    end
    n_tests++;
    if (ip_send_type !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_send_type: got %h want 11", ip_send_type);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_udp;
    bit seen;
    int n;
    done_delay = 5;
    @(negedge clk);
    load_pkt(1'b0, 10, 64'h0, 8'hff);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (udp_tvalid) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen || grant_udp !== 1'b0 || udp_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_arb_cycle: got seen=%b grant=%b tready=%b, want 1 0 0", seen, grant_udp, udp_tready);
    end
    @(negedge clk);
    n_tests++;
    if ({grant_udp, grant_icmp} !== 2'b10 || ip_send_type !== 8'h11) begin
      n_fail++;
      $display("FAIL single_grant: got gu=%b gi=%b type=%h, want 1 0 11", grant_udp, grant_icmp, ip_send_type);
    end
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tb_hs_last) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!grant_udp) break;
    end
    n_tests++;
    if (!seen || n != 6) begin
      n_fail++;
      $display("FAIL single_release: got tlast_seen=%b release_after=%0d, want 1 6", seen, n);
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain: got %0d beats missing, want 0", sb_q.size());
    end
  endtask

  task automatic test_tie;
    int n;
    int leak;
    bit icmp_seen;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_delay = 2;
    load_pkt(1'b0, 4, 64'hA000, 8'hff);
    load_pkt(1'b1, 4, 64'hB000, 8'h3f);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant_udp || grant_icmp) break;
    end
    n_tests++;
    if ({grant_udp, grant_icmp} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_first: got gu=%b gi=%b, want 1 0", grant_udp, grant_icmp);
    end
    n = 0; leak = 0; icmp_seen = 1'b0;
    while (n < 200 && !(udp_src_q.size() == 0 && icmp_src_q.size() == 0 && !grant_udp && !grant_icmp)) begin
      if (grant_udp && icmp_tready) leak++;
      if (grant_icmp) icmp_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 200 || leak != 0 || !icmp_seen || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL tie_sequence: got cycles=%0d icmp_ready_leaks=%0d icmp_granted=%b left=%0d, want <200 0 1 0",
               n, leak, icmp_seen, sb_q.size());
    end
  endtask

  task automatic test_backpressure;
    int n;
    int start_cnt;
    done_delay = 2;
    rdy_toggle = 1'b1;
    start_cnt = beat_cnt;
    @(negedge clk);
    load_pkt(1'b1, 20, 64'hC0DE_0000_0000_0000, 8'h0f);
    n = 0;
    while (n < 300 && !(icmp_src_q.size() == 0 && !grant_icmp)) begin
      @(negedge clk);
      n++;
    end
    rdy_toggle = 1'b0;
    n_tests++;
    if (n >= 300 || beat_cnt - start_cnt != 20 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL backpressure: got cycles=%0d beats=%0d left=%0d, want <300 20 0", n, beat_cnt - start_cnt, sb_q.size());
    end
  endtask

  task automatic test_timeout;
    int n;
    int first;
    int pulses;
    bit seen;
    bit gu18;
    done_delay = -1;
    @(negedge clk);
    load_pkt(1'b1, 3, 64'hD000, 8'hff);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant_icmp) break;
    end
    load_pkt(1'b0, 2, 64'hE000, 8'hff);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tb_hs_last) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n = 0; first = -1; pulses = 0; gu18 = 1'b0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (timeout_err) begin
        pulses++;
        if (first < 0) first = n;
      end
      if (n == 17) done_delay = 3;
      if (n == 18) gu18 = grant_udp;
    end
    n_tests++;
    if (!seen || first != 17) begin
      n_fail++;
      $display("FAIL timeout_delay: got tlast_seen=%b pulse_at=%0d, want 1 17", seen, first);
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: got %0d cycles high, want 1", pulses);
    end
    n_tests++;
    if (gu18 !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_next_grant: got grant_udp=%b, want 1", gu18);
    end
    n = 0;
    while (n < 100 && !(udp_src_q.size() == 0 && !grant_udp)) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 100 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_drain: got cycles=%0d left=%0d, want <100 0", n, sb_q.size());
    end
  endtask

  task automatic test_same_cycle_done;
    int n;
    bit seen;
    done_delay = 0;
    @(negedge clk);
    load_pkt(1'b0, 3, 64'hF000, 8'hff);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant_udp) break;
    end
    load_pkt(1'b1, 2, 64'hF100, 8'hff);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tb_hs_last) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_tests++;
    if (!seen || {grant_udp, grant_icmp} !== 2'b00) begin
      n_fail++;
      $display("FAIL same_cycle_release: got tlast_seen=%b gu=%b gi=%b, want 1 0 0", seen, grant_udp, grant_icmp);
    end
    @(negedge clk);
    n_tests++;
    if (grant_icmp !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_next_grant: got grant_icmp=%b, want 1", grant_icmp);
    end
    n = 0;
    while (n < 100 && !(icmp_src_q.size() == 0 && !grant_icmp)) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 100 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL same_cycle_drain: got cycles=%0d left=%0d, want <100 0", n, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_packet;
    int hs_n;
    done_delay = 2;
    @(negedge clk);
    load_pkt(1'b1, 10, 64'h5000, 8'hff);
    hs_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ip_tvalid && ip_tready) hs_n++;
      if (hs_n == 5) break;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (hs_n != 5 || ip_send_type !== 8'h01 || grant_icmp !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_before: got beats=%0d type=%h gi=%b, want 5 01 1", hs_n, ip_send_type, grant_icmp);
    end
    @(negedge clk);
    n_tests++;
    if ({udp_tready, icmp_tready, ip_tvalid, grant_udp, grant_icmp} !== 5'b0 || ip_send_type !== 8'h11) begin
      n_fail++;
      $display("FAIL midreset_after: got ur=%b ir=%b v=%b gu=%b gi=%b type=%h, want 0 0 0 0 0 11",
               udp_tready, icmp_tready, ip_tvalid, grant_udp, grant_icmp, ip_send_type);
    end
    icmp_src_q.delete();
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    test_reset();
    test_single_udp();
    test_tie();
    test_backpressure();
    test_timeout();
    test_same_cycle_done();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
